// File: rtl/rholang_pkg.sv
// Shared constants and types for the Rholang program decoder: stream
// opcodes, parse error causes, parser states and the queued descriptor.
package rholang_pkg;

  localparam int RHO_FPU_ID_WIDTH = 4;

  localparam logic [3:0] OP_BEGIN = 4'h1;
  localparam logic [3:0] OP_PROC  = 4'h2;
  localparam logic [3:0] OP_END   = 4'hF;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_SEQ      = 3'd1;
  localparam logic [2:0] ERR_TOO_MANY = 3'd2;
  localparam logic [2:0] ERR_TYPE     = 3'd3;
  localparam logic [2:0] ERR_COUNT    = 3'd4;
  localparam logic [2:0] ERR_OPCODE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_LOADED,
    ST_DISPATCH,
    ST_ERROR
  } parser_state_t;

  typedef struct packed {
    logic [RHO_FPU_ID_WIDTH-1:0] fpu_id;
    logic [3:0]                  ptype;
    logic [31:0]                 data;
  } desc_t;

  // States in which the host word stream is being consumed.
  function automatic logic accepts_words(parser_state_t s);
    return (s == ST_IDLE) || (s == ST_HDR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/rholang_program_decoder_if.sv
// Host word stream plus process-init port. The decoder is the slave side,
// the host/process-manager pair is the master side.
interface rholang_program_decoder_if #(
  parameter int FPU_ID_WIDTH = 4
);
  logic [31:0]             program_data;
  logic                    program_valid;
  logic                    program_ready;
  logic [FPU_ID_WIDTH-1:0] init_fpu_id;
  logic [3:0]              init_process_type;
  logic [31:0]             init_process_data;
  logic                    init_valid;
  logic                    init_ready;

  modport master (
    output program_data, program_valid, init_ready,
    input  program_ready, init_fpu_id, init_process_type, init_process_data, init_valid
  );

  modport slave (
    input  program_data, program_valid, init_ready,
    output program_ready, init_fpu_id, init_process_type, init_process_data, init_valid
  );
endinterface

// File: rtl/rholang_desc_fifo.sv
// Descriptor queue: synchronous FIFO with first-word-fall-through head,
// extra pointer bit to tell full from empty, and a soft clear.
module rholang_desc_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage write; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; clear flushes by realigning both pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/rholang_program_decoder.sv
// Parses BEGIN/PROC/END descriptor streams into a queue and, on start,
// dispatches the queued descriptors to the process-management init port.
module rholang_program_decoder
  import rholang_pkg::*;
#(
  parameter int NUM_FPUS     = 16,
  parameter int FPU_ID_WIDTH = RHO_FPU_ID_WIDTH,
  parameter int DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  rholang_program_decoder_if.slave  bus,
  input  logic                      start_execution,
  input  logic                      clear,
  output logic                      program_loaded,
  output logic                      dispatch_done,
  output logic                      error,
  output logic [2:0]                error_code,
  output logic [15:0]               record_count
);
  localparam int          AW          = $clog2(DEPTH);
  localparam int          DESC_W      = FPU_ID_WIDTH + 4 + 32;
  localparam logic [15:0] DEPTH_LIMIT = 16'(DEPTH);
  localparam logic [AW:0] ONE_LEFT    = (AW+1)'(1);

  if (NUM_FPUS > (1 << FPU_ID_WIDTH)) begin : g_fpu_range_check
    $error("NUM_FPUS does not fit in FPU_ID_WIDTH bits");
  end

  parser_state_t           state, state_next;
  logic [15:0]             n_reg, n_next;
  logic [3:0]              type_reg, type_next;
  logic [FPU_ID_WIDTH-1:0] id_reg, id_next;
  logic [15:0]             count_reg, count_next;
  logic                    error_reg, error_next;
  logic [2:0]              code_reg, code_next;
  logic                    ready_reg;
  logic                    done_reg, done_next;

  logic                    fifo_push, fifo_pop, fifo_clear;
  logic                    fifo_full, fifo_empty;
  logic [AW:0]             fifo_level;
  logic [DESC_W-1:0]       fifo_head;
  logic [FPU_ID_WIDTH-1:0] head_id;
  logic [3:0]              head_type;
  logic [31:0]             head_data;

  logic [3:0]              opcode;
  logic                    word_accept;
  logic                    raise_err;
  logic [2:0]              raise_code;
  logic                    init_valid_w;

  assign opcode      = bus.program_data[31:28];
  assign word_accept = bus.program_valid && ready_reg;

  rholang_desc_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data ({id_reg, type_reg, bus.program_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Next-state, queue control and error capture; clear overrides everything.
  always_comb begin
    state_next = state;
    n_next     = n_reg;
    type_next  = type_reg;
    id_next    = id_reg;
    count_next = count_reg;
    error_next = error_reg;
    code_next  = code_reg;
    done_next  = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    raise_err  = 1'b0;
    raise_code = ERR_NONE;

    unique case (state)
      ST_IDLE: if (word_accept) begin
        if (opcode != OP_BEGIN) begin
          raise_err = 1'b1; raise_code = ERR_SEQ;
        end else if (bus.program_data[15:0] > DEPTH_LIMIT) begin
          raise_err = 1'b1; raise_code = ERR_TOO_MANY;
        end else begin
          state_next = ST_HDR;
          n_next     = bus.program_data[15:0];
          count_next = '0;
        end
      end
      ST_HDR: if (word_accept) begin
        if (opcode == OP_PROC) begin
          if (bus.program_data[27:24] == 4'h0) begin
            raise_err = 1'b1; raise_code = ERR_TYPE;
          end else if (count_reg == n_reg) begin
            raise_err = 1'b1; raise_code = ERR_COUNT;
          end else begin
            type_next  = bus.program_data[27:24];
            id_next    = bus.program_data[FPU_ID_WIDTH-1:0];
            state_next = ST_DATA;
          end
        end else if (opcode == OP_END) begin
          if (count_reg == n_reg) state_next = ST_LOADED;
          else begin raise_err = 1'b1; raise_code = ERR_COUNT; end
        end else if (opcode == OP_BEGIN) begin
          raise_err = 1'b1; raise_code = ERR_SEQ;
        end else begin
          raise_err = 1'b1; raise_code = ERR_OPCODE;
        end
      end
      ST_DATA: if (word_accept) begin
        fifo_push  = !fifo_full;
        count_next = count_reg + 16'd1;
        state_next = ST_HDR;
      end
      ST_LOADED: if (start_execution) begin
        // An empty program completes as soon as it is started.
        if (fifo_empty) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
        end else if (bus.init_ready) begin
          fifo_pop = 1'b1;
          if (fifo_level == ONE_LEFT) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      ST_ERROR: ;
      default: state_next = ST_IDLE;
    endcase

    if (raise_err) begin
      state_next = ST_ERROR;
      error_next = 1'b1;
      code_next  = raise_code;
    end

    if (clear) begin
      state_next = ST_IDLE;
      count_next = '0;
      error_next = 1'b0;
      code_next  = ERR_NONE;
      done_next  = 1'b0;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_clear = 1'b1;
    end
  end

  // Parser registers; ready is registered so it reads 0 while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      n_reg     <= '0;
      type_reg  <= '0;
      id_reg    <= '0;
      count_reg <= '0;
      error_reg <= 1'b0;
      code_reg  <= ERR_NONE;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state     <= state_next;
      n_reg     <= n_next;
      type_reg  <= type_next;
      id_reg    <= id_next;
      count_reg <= count_next;
      error_reg <= error_next;
      code_reg  <= code_next;
      ready_reg <= accepts_words(state_next);
      done_reg  <= done_next;
    end
  end

  // Payload is forced to zero whenever nothing is being offered.
  assign {head_id, head_type, head_data} = fifo_head;
  assign init_valid_w          = (state == ST_DISPATCH) && !fifo_empty;
  assign bus.init_valid        = init_valid_w;
  assign bus.init_fpu_id       = init_valid_w ? head_id   : '0;
  assign bus.init_process_type = init_valid_w ? head_type : '0;
  assign bus.init_process_data = init_valid_w ? head_data : '0;
  assign bus.program_ready     = ready_reg;

  assign program_loaded = (state == ST_LOADED);
  assign dispatch_done  = done_reg;
  assign error          = error_reg;
  assign error_code     = code_reg;
  assign record_count   = count_reg;
endmodule

// File: tb/tb_rholang_program_decoder.sv
// Directed and randomized checks of the program decoder against a
// sequential word-walking reference parser.
module tb_rholang_program_decoder;
  import rholang_pkg::*;

  localparam int DEPTH = 16;
  localparam int DRAIN_LIMIT = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_execution = 1'b0;
  logic        clear = 1'b0;
  logic        program_loaded, dispatch_done, error;
  logic [2:0]  error_code;
  logic [15:0] record_count;

  int n_checks = 0;
  int n_errors = 0;

  rholang_program_decoder_if #(.FPU_ID_WIDTH(4)) bus ();

  rholang_program_decoder #(
    .NUM_FPUS     (16),
    .FPU_ID_WIDTH (4),
    .DEPTH        (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .start_execution (start_execution),
    .clear           (clear),
    .program_loaded  (program_loaded),
    .dispatch_done   (dispatch_done),
    .error           (error),
    .error_code      (error_code),
    .record_count    (record_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference parser: walks the word list in order and reports how many
  // words the decoder takes, the error cause and the descriptors queued.
  function automatic void ref_parse(input logic [31:0] w[$], output int used,
                                    output int code, output bit loaded, output desc_t d[$]);
    int n;
    int i;
    logic [31:0] cur;
    desc_t x;
    used = 0; code = 0; loaded = 1'b0; d = {};
    if (w.size() == 0) return;
    used = 1;
    cur = w[0];
    if (cur[31:28] != 4'h1) begin code = 1; return; end
    n = int'(cur[15:0]);
    if (n > DEPTH) begin code = 2; return; end
    i = 1;
    while (i < w.size()) begin
      used = i + 1;
      cur = w[i];
      case (cur[31:28])
        4'h2: begin
          if (cur[27:24] == 4'h0) begin code = 3; return; end
          if (d.size() == n) begin code = 4; return; end
          if (i + 1 >= w.size()) return;
          used = i + 2;
          x.fpu_id = cur[3:0];
          x.ptype  = cur[27:24];
          x.data   = w[i+1];
          d.push_back(x);
          i += 2;
        end
        4'hF: begin
          if (d.size() != n) code = 4; else loaded = 1'b1;
          return;
        end
        4'h1: begin code = 1; return; end
        default: begin code = 5; return; end
      endcase
    end
  endfunction

  function automatic void gen_prog(input int n, output logic [31:0] w[$]);
    logic [3:0] ty;
    logic [3:0] id;
    w = {};
    w.push_back({4'h1, 12'h000, 16'(n)});
    for (int i = 0; i < n; i++) begin
      ty = 4'($urandom_range(1, 15));
      id = 4'($urandom_range(0, 15));
      w.push_back({4'h2, ty, 20'($urandom()), id});
      w.push_back($urandom());
    end
    w.push_back({4'hF, 28'($urandom())});
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},   32'(bus.program_ready), 32'd0);
    chk({tag, "_ivalid"},  32'(bus.init_valid), 32'd0);
    chk({tag, "_iid"},     32'(bus.init_fpu_id), 32'd0);
    chk({tag, "_itype"},   32'(bus.init_process_type), 32'd0);
    chk({tag, "_idata"},   bus.init_process_data, 32'd0);
    chk({tag, "_loaded"},  32'(program_loaded), 32'd0);
    chk({tag, "_done"},    32'(dispatch_done), 32'd0);
    chk({tag, "_error"},   32'(error), 32'd0);
    chk({tag, "_code"},    32'(error_code), 32'd0);
    chk({tag, "_count"},   32'(record_count), 32'd0);
  endtask

  task automatic load_prog(input string tag, input logic [31:0] w[$],
                           output int code, output bit loaded, output desc_t d[$]);
    int used;
    ref_parse(w, used, code, loaded, d);
    for (int i = 0; i < used; i++) begin
      chk({tag, "_ready"}, 32'(bus.program_ready), 32'd1);
      bus.program_data  = w[i];
      bus.program_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.program_valid = 1'b0;
    chk({tag, "_error"},  32'(error), 32'(code != 0));
    chk({tag, "_code"},   32'(error_code), 32'(code));
    chk({tag, "_loaded"}, 32'(program_loaded), 32'(loaded));
    chk({tag, "_pready"}, 32'(bus.program_ready), 32'(code == 0 && !loaded));
    if (!(used == 1 && code != 0)) chk({tag, "_count"}, 32'(record_count), 32'(d.size()));
    $display("txn load %s words=%0d code=%0d loaded=%0d records=%0d", tag, used, code, loaded, d.size());
  endtask

  task automatic start_and_drain(input string tag, input desc_t exp[$], input int mode);
    logic [3:0] pat;
    int  k;
    int  cyc;
    int  total;
    logic r;
    pat = 4'b1001; k = 0; cyc = 0; total = exp.size();
    start_execution = 1'b1;
    @(posedge clk); #1;
    start_execution = 1'b0;
    while (exp.size() > 0 && cyc < DRAIN_LIMIT) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = pat[k % 4];
      else                r = 1'($urandom_range(0, 1));
      bus.init_ready = r;
      chk({tag, "_ivalid"}, 32'(bus.init_valid), 32'd1);
      chk({tag, "_iid"},    32'(bus.init_fpu_id), 32'(exp[0].fpu_id));
      chk({tag, "_itype"},  32'(bus.init_process_type), 32'(exp[0].ptype));
      chk({tag, "_idata"},  bus.init_process_data, exp[0].data);
      chk({tag, "_early_done"}, 32'(dispatch_done), 32'd0);
      @(posedge clk); #1;
      k++; cyc++;
      if (r) void'(exp.pop_front());
    end
    bus.init_ready = 1'b0;
    chk({tag, "_left"},     32'(exp.size()), 32'd0);
    chk({tag, "_done"},     32'(dispatch_done), 32'd1);
    chk({tag, "_ivalid_end"}, 32'(bus.init_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(dispatch_done), 32'd0);
    chk({tag, "_pready_end"}, 32'(bus.program_ready), 32'd1);
    $display("txn dispatch %s descriptors=%0d cycles=%0d mode=%0d", tag, total, cyc, mode);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk({tag, "_error"},  32'(error), 32'd0);
    chk({tag, "_code"},   32'(error_code), 32'd0);
    chk({tag, "_pready"}, 32'(bus.program_ready), 32'd1);
    chk({tag, "_ivalid"}, 32'(bus.init_valid), 32'd0);
    $display("txn clear %s", tag);
  endtask

  initial begin
    logic [31:0] w[$];
    desc_t d[$];
    int code;
    bit loaded;

    bus.program_data = '0;
    bus.program_valid = 1'b0;
    bus.init_ready = 1'b0;

    // Reset state, then release
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(bus.program_ready), 32'd1);
    chk("post_reset_error", 32'(error), 32'd0);

    // start outside LOADED is ignored
    start_execution = 1'b1;
    @(posedge clk); #1;
    start_execution = 1'b0;
    chk("idle_start_ivalid", 32'(bus.init_valid), 32'd0);
    chk("idle_start_done", 32'(dispatch_done), 32'd0);
    chk("idle_start_ready", 32'(bus.program_ready), 32'd1);

    // Basic two-record program, full-rate consumer
    w = {32'h1000_0002, 32'h2300_0005, 32'hDEAD_BEEF, 32'h2100_0000, 32'h1234_5678, 32'hF000_0000};
    load_prog("basic", w, code, loaded, d);
    start_and_drain("basic", d, 0);

    // Same program with a stalling consumer
    load_prog("stall", w, code, loaded, d);
    start_and_drain("stall", d, 1);

    // Error cases, each followed by clear
    w = {32'h1000_0011};
    load_prog("too_many", w, code, loaded, d);
    do_clear("too_many");
    w = {32'h1000_0001, 32'h2200_0003, 32'h0000_0001, 32'h2200_0004};
    load_prog("extra_proc", w, code, loaded, d);
    do_clear("extra_proc");
    w = {32'h1000_0002, 32'h2400_0007, 32'hCAFE_0001, 32'hF000_0000};
    load_prog("short_end", w, code, loaded, d);
    do_clear("short_end");
    w = {32'h1000_0001, 32'h2000_0002};
    load_prog("type0", w, code, loaded, d);
    do_clear("type0");
    w = {32'h1000_0001, 32'h5000_0000};
    load_prog("bad_op", w, code, loaded, d);
    do_clear("bad_op");
    w = {32'h2300_0001};
    load_prog("idle_proc", w, code, loaded, d);
    do_clear("idle_proc");
    w = {32'h1000_0003, 32'h1000_0001};
    load_prog("hdr_begin", w, code, loaded, d);
    do_clear("hdr_begin");

    // Empty program: immediate completion
    w = {32'h1000_0000, 32'hF000_0000};
    load_prog("empty", w, code, loaded, d);
    start_and_drain("empty", d, 0);

    // Exactly DEPTH records, three times back to back (pointer wrap)
    for (int rep = 0; rep < 3; rep++) begin
      gen_prog(DEPTH, w);
      load_prog("full", w, code, loaded, d);
      start_and_drain("full", d, 0);
    end

    // Clear mid-dispatch flushes the queue
    gen_prog(4, w);
    load_prog("clr_disp", w, code, loaded, d);
    start_execution = 1'b1;
    @(posedge clk); #1;
    start_execution = 1'b0;
    bus.init_ready = 1'b1;
    chk("clr_disp_first", bus.init_process_data, d[0].data);
    @(posedge clk); #1;
    bus.init_ready = 1'b0;
    do_clear("clr_disp");
    gen_prog(2, w);
    load_prog("after_clr", w, code, loaded, d);
    start_and_drain("after_clr", d, 2);

    // Random programs, some with one corrupted word
    for (int t = 0; t < 10; t++) begin
      gen_prog($urandom_range(0, DEPTH), w);
      if ($urandom_range(0, 1) == 1) begin
        w[$urandom_range(0, w.size() - 1)] = {4'($urandom_range(0, 15)), 28'($urandom())};
      end
      load_prog("rand", w, code, loaded, d);
      if (loaded) start_and_drain("rand", d, 2);
      else do_clear("rand");
    end

    // Reset in the middle of an 8-record dispatch
    gen_prog(8, w);
    load_prog("rst_disp", w, code, loaded, d);
    start_execution = 1'b1;
    @(posedge clk); #1;
    start_execution = 1'b0;
    bus.init_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      chk("rst_disp_beat", bus.init_process_data, d[b].data);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_ready", 32'(bus.program_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk("rst_no_dispatch", 32'(bus.init_valid), 32'd0);
      chk("rst_no_done", 32'(dispatch_done), 32'd0);
      @(posedge clk); #1;
    end
    bus.init_ready = 1'b0;
    $display("txn reset_mid_dispatch");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
